// File: rtl/rto_pkg.sv
// ---------------------------------------------------------------------------
// rto_pkg
// Shared definitions for the RTO controllers.
//   rto_seq_state_t : write-sequencer state, also driven out on state_o
//                     (00 IDLE, 01 RUN, 10 FLUSH, 11 HALT)
//   TS_MSB / TS_LSB : timestamp field of a 128-bit event word
//   ERR_OVF / ERR_TS: bit positions in err_cause
// ---------------------------------------------------------------------------
package rto_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } rto_seq_state_t;

    localparam int TS_MSB  = 127;
    localparam int TS_LSB  = 64;

    localparam int ERR_OVF = 0;
    localparam int ERR_TS  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant with a registered priority pointer.
// The grant goes to the lowest index >= pointer whose request is set,
// wrapping at NUM_REQ. On advance the pointer moves to grant_idx+1.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (pointer -> 0)
//   req         : request vector
//   advance     : a grant was consumed this cycle
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_idx   : binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        // Scan NUM_REQ positions starting at the pointer; first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rto_write_sequencer.sv
// ---------------------------------------------------------------------------
// rto_write_sequencer
// Front-end controller for one RTO_Core. Merges NUM_REQ event streams into
// the core's single write port (round robin), and sequences auto_start and
// flush through IDLE/RUN/FLUSH/HALT. A core error while running halts the
// core, flushes it, and latches the cause until software clears it.
//
// Handshake: requester i transfers an event on a rising edge where
// req_valid[i] & req_ready[i]. req_ready is asserted only for the granted
// requester, and only while the sequencer is open (IDLE or RUN) and the core
// is not full. An accepted event appears on core_write/core_din during the
// following cycle.
//
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   req_valid/_data  : per-requester event; requester i at [i*DATA_W +: DATA_W]
//   req_ready        : per-requester accept
//   ctrl_start/stop/clear : software control pulses
//   core_full/empty/ovf_err/ts_err : RTO_Core status
//   core_write, core_din, core_auto_start, core_flush : RTO_Core controls
//   state_o          : current state (debug / status)
//   err_cause        : {ts, ovf} sticky error cause
//   write_count      : events written since the last entry to IDLE
// ---------------------------------------------------------------------------
module rto_write_sequencer
    import rto_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 128,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      ctrl_start,
    input  logic                      ctrl_stop,
    input  logic                      ctrl_clear,
    input  logic                      core_full,
    input  logic                      core_empty,
    input  logic                      core_ovf_err,
    input  logic                      core_ts_err,
    output logic                      core_write,
    output logic [DATA_W-1:0]         core_din,
    output logic                      core_auto_start,
    output logic                      core_flush,
    output logic [1:0]                state_o,
    output logic [1:0]                err_cause,
    output logic [31:0]               write_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    rto_seq_state_t    state, state_next;
    logic [FC_W-1:0]   flush_cnt;
    logic [1:0]        err_set;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept_ok;
    logic               handshake;
    logic               next_open;
    logic [DATA_W-1:0]  din_sel;

    logic               wr_q;
    logic [DATA_W-1:0]  din_q;

    // Core emptiness is not needed for sequencing; kept on the port list so
    // the controller drops straight onto the core's status bundle.
    logic unused_core_empty;
    assign unused_core_empty = core_empty;

    // ---------------- arbitration and acceptance ----------------
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept_ok = ~core_full & ((state == IDLE) | (state == RUN));
    assign req_ready = accept_ok ? grant : '0;
    assign handshake = accept_ok & (|grant);

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                din_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- state machine ----------------
    always_comb begin
        state_next = state;
        err_set    = 2'b00;
        case (state)
            IDLE: begin
                // start wins over a simultaneous stop here
                if (ctrl_start) state_next = RUN;
            end
            RUN: begin
                // an error outranks stop so the cause is always recorded
                if (core_ovf_err | core_ts_err) begin
                    state_next      = FLUSH;
                    err_set[ERR_OVF] = core_ovf_err;
                    err_set[ERR_TS]  = core_ts_err;
                end else if (ctrl_stop) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FC_W'(1)) begin
                    state_next = (err_cause != 2'b00) ? HALT : IDLE;
                end
            end
            HALT: begin
                if (ctrl_clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loaded on FLUSH entry, counts down the cycles spent in FLUSH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flush_cnt <= '0;
        end else if ((state != FLUSH) && (state_next == FLUSH)) begin
            flush_cnt <= FC_W'(FLUSH_CYCLES);
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cause <= 2'b00;
        end else if ((state == HALT) && ctrl_clear) begin
            err_cause <= 2'b00;
        end else begin
            err_cause <= err_cause | err_set;
        end
    end

    // ---------------- write output register ----------------
    // A write accepted on the edge that enters FLUSH is dropped: the core is
    // being flushed and must not see new data.
    assign next_open = (state_next == IDLE) | (state_next == RUN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= 1'b0;
            din_q <= '0;
        end else begin
            wr_q <= handshake & next_open;
            if (handshake) begin
                din_q <= din_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            write_count <= '0;
        end else if ((state_next == IDLE) && (state != IDLE)) begin
            write_count <= '0;
        end else if (wr_q) begin
            write_count <= write_count + 32'd1;
        end
    end

    assign core_write      = wr_q;
    assign core_din        = din_q;
    assign core_auto_start = (state == RUN);
    assign core_flush      = (state == FLUSH);
    assign state_o         = state;

endmodule

// File: tb/tb_rto_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rto_write_sequencer
// Directed bench for rto_write_sequencer (NUM_REQ=4, DATA_W=128,
// FLUSH_CYCLES=4). A behavioural model tracks what the outputs must be;
// a negedge process compares every output against it each cycle, and the
// directed sequence pins key values with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_rto_write_sequencer;

  localparam int N  = 4;
  localparam int W  = 128;
  localparam int FC = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FLUSH = 2;
  localparam int S_HALT  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_clear = 1'b0;
  logic           core_full = 1'b0, core_empty = 1'b1;
  logic           core_ovf_err = 1'b0, core_ts_err = 1'b0;
  logic           core_write;
  logic [W-1:0]   core_din;
  logic           core_auto_start, core_flush;
  logic [1:0]     state_o, err_cause;
  logic [31:0]    write_count;

  rto_write_sequencer #(.NUM_REQ(N), .DATA_W(W), .FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .ctrl_clear      (ctrl_clear),
    .core_full       (core_full),
    .core_empty      (core_empty),
    .core_ovf_err    (core_ovf_err),
    .core_ts_err     (core_ts_err),
    .core_write      (core_write),
    .core_din        (core_din),
    .core_auto_start (core_auto_start),
    .core_flush      (core_flush),
    .state_o         (state_o),
    .err_cause       (err_cause),
    .write_count     (write_count)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_on = 0;
  int          m_state, m_ptr, m_left;
  bit          m_wr;
  logic [W-1:0] m_din;
  logic [1:0]  m_err;
  logic [31:0] m_cnt;

  // Requester that would be served: first valid one at or after the pointer.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_open();
    return !core_full && (m_state == S_IDLE || m_state == S_RUN);
  endfunction

  always @(posedge clk) begin
    int g, ns;
    bit hs;
    if (!resetn) begin
      m_on = 1; m_state = S_IDLE; m_ptr = 0; m_left = 0;
      m_wr = 0; m_din = '0; m_err = 2'b00; m_cnt = 0;
    end else if (m_on) begin
      g  = model_grant();
      hs = (g >= 0) && model_open();
      ns = m_state;
      case (m_state)
        S_IDLE:  if (ctrl_start) ns = S_RUN;
        S_RUN: begin
          if (core_ovf_err || core_ts_err) begin
            ns = S_FLUSH;
            m_err = m_err | {core_ts_err, core_ovf_err};
          end else if (ctrl_stop) begin
            ns = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (m_left == 1) ns = (m_err != 0) ? S_HALT : S_IDLE;
          else m_left--;
        end
        default: if (ctrl_clear) begin ns = S_IDLE; m_err = 2'b00; end
      endcase
      if (ns == S_FLUSH && m_state != S_FLUSH) m_left = FC;
      if (m_wr) m_cnt++;
      if (ns == S_IDLE && m_state != S_IDLE) m_cnt = 0;
      m_wr = hs && (ns == S_IDLE || ns == S_RUN);
      if (hs) begin
        m_din = req_data[g*W +: W];
        m_ptr = (g + 1) % N;
      end
      m_state = ns;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ready;
    if (m_on) begin
      g = model_grant();
      exp_ready = (g >= 0 && model_open()) ? (N'(1) << g) : '0;
      check("state_o", W'(state_o), W'(m_state[1:0]));
      check("req_ready", W'(req_ready), W'(exp_ready));
      check("core_write", W'(core_write), W'(m_wr));
      if (m_wr) check("core_din", core_din, m_din);
      check("auto_start", W'(core_auto_start), W'(m_state == S_RUN));
      check("core_flush", W'(core_flush), W'(m_state == S_FLUSH));
      check("err_cause", W'(err_cause), W'(m_err));
      check("write_count", W'(write_count), W'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Event word: timestamp 0x1000+i, tag in the middle, source index in [7:0].
  task automatic load_data(input int tag);
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = {64'h1000 + 64'(i), 32'(tag), 24'h0, 8'(i)};
    end
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1; tick(1); ctrl_start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int src [8];
  int nflush;

  initial begin
    load_data(1);
    tick(2);
    resetn = 1'b1;

    // reset state
    check("rst_state", W'(state_o), 0);
    check("rst_write", W'(core_write), 0);
    check("rst_din", core_din, 0);
    check("rst_err", W'(err_cause), 0);
    check("rst_count", W'(write_count), 0);
    check("rst_auto_flush", W'({core_auto_start, core_flush}), 0);

    // preload 5 events from requester 3 while IDLE
    req_valid = 4'b1000;
    tick(1);
    check("preload_write", W'({core_write, core_auto_start}), W'(2'b10));
    tick(4);
    req_valid = '0;
    tick(1);
    pulse_start();
    check("start_state", W'(state_o), 1);
    check("start_auto", W'(core_auto_start), 1);
    check("preload_count", W'(write_count), 5);

    // fairness: all four valid for 8 cycles
    load_data(2);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      src[c] = core_write ? int'(core_din[7:0]) : 99;
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) check("rr_order", W'(src[c]), W'(c % 4));

    // backpressure on requester 2
    load_data(3);
    core_full = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("bp_ready", W'(req_ready), 0);
      check("bp_write", W'(core_write), 0);
    end
    core_full = 1'b0;
    #1;
    check("bp_ready_release", W'(req_ready), W'(4'b0100));
    tick(1);
    req_valid = '0;
    check("bp_write_release", W'(core_write), 1);
    check("bp_din", core_din, {64'h1002, 32'd3, 24'h0, 8'd2});

    // overflow error while a write is being accepted
    req_valid = 4'b0001;
    core_ovf_err = 1'b1;
    tick(1);
    core_ovf_err = 1'b0;
    check("ovf_suppressed_write", W'(core_write), 0);
    check("ovf_auto_off", W'(core_auto_start), 0);
    nflush = 0;
    for (int c = 0; c < 6; c++) begin
      if (core_flush) nflush++;
      tick(1);
    end
    check("ovf_flush_cycles", W'(nflush), 4);
    check("ovf_halt", W'(state_o), 3);
    check("ovf_cause", W'(err_cause), W'(2'b01));
    check("halt_ready", W'(req_ready), 0);
    core_ts_err = 1'b1;
    tick(1);
    core_ts_err = 1'b0;
    check("halt_err_ignored", W'(err_cause), W'(2'b01));
    req_valid = '0;
    ctrl_clear = 1'b1; tick(1); ctrl_clear = 1'b0;
    check("clear_state", W'(state_o), 0);
    check("clear_cause", W'(err_cause), 0);
    check("clear_count", W'(write_count), 0);

    // clean stop; start+stop together in RUN -> stop wins
    pulse_start();
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    tick(1);
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    check("stop_flush", W'(state_o), 2);
    tick(4);
    check("stop_idle", W'(state_o), 0);
    check("stop_cause", W'(err_cause), 0);
    // start+stop together in IDLE -> start wins
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    tick(1);
    ctrl_start = 1'b0;
    check("idle_start_wins", W'(state_o), 1);
    // stop and timestamp error together -> error path
    core_ts_err = 1'b1;
    tick(1);
    ctrl_stop = 1'b0; core_ts_err = 1'b0;
    tick(4);
    check("ts_halt", W'(state_o), 3);
    check("ts_cause", W'(err_cause), W'(2'b10));
    ctrl_clear = 1'b1; tick(1); ctrl_clear = 1'b0;

    // reset the cycle after a handshake
    load_data(4);
    req_valid = 4'b0010;
    tick(1);
    check("pre_rst_write", W'(core_write), 1);
    req_valid = '0;
    resetn = 1'b0;
    tick(1);
    check("mid_rst_write", W'(core_write), 0);
    check("mid_rst_outputs", W'({core_auto_start, core_flush, state_o, err_cause}), 0);
    check("mid_rst_count", W'(write_count), 0);
    resetn = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("rst_ptr_zero", W'(req_ready), W'(4'b0001));
    tick(1);
    req_valid = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
